// File: rtl/fifo_sync_checker.sv
// Passive on-chip checker for a synchronous FIFO: shadow model + per-cycle compare, saturating pass/fail counters.
// Latency: mismatch visible on counters one clk after the sampled edge; no backpressure, taps only.
`timescale 1ns/1ps
module fifo_sync_checker #(
  parameter int         FIFO_WIDTH = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter int         AF_LVL     = FIFO_DEPTH - 1,
  parameter int         AE_LVL     = 1,
  parameter int         CNT_W      = 16,
  parameter logic [7:0] CHK_MASK   = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chk_en,
  input  logic                  mon_rst_n,
  input  logic                  mon_wr_en,
  input  logic                  mon_rd_en,
  input  logic [FIFO_WIDTH-1:0] mon_data_in,
  input  logic [FIFO_WIDTH-1:0] mon_data_out,
  input  logic [6:0]            mon_flags,
  output logic [CNT_W-1:0]      correct_cnt,
  output logic [CNT_W-1:0]      error_cnt,
  output logic                  err_sticky,
  output logic [7:0]            first_err_mask,
  output logic [CNT_W-1:0]      first_err_cyc
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] AF_C     = OCC_W'(AF_LVL);
  localparam logic [OCC_W-1:0] AE_C     = OCC_W'(AE_LVL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] SAT      = '1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wp, rp;
  logic [OCC_W-1:0]      cnt;
  logic [FIFO_WIDTH-1:0] exp_dout;
  logic                  exp_wr_ack, exp_ovf, exp_udf;
  logic                  cmp_valid;
  logic [CNT_W-1:0]      cycle_cnt;

  logic       full_m, empty_m, wr_ok, rd_ok;
  logic [6:0] exp_flags;
  logic [7:0] mism;

  assign full_m  = (cnt == DEPTH_C);
  assign empty_m = (cnt == '0);
  assign wr_ok   = mon_wr_en && !full_m;
  assign rd_ok   = mon_rd_en && !empty_m;

  // Same bit order as mon_flags: {wr_ack,underflow,overflow,almostempty,almostfull,empty,full}
  assign exp_flags = {exp_wr_ack, exp_udf, exp_ovf, (cnt == AE_C), (cnt == AF_C), empty_m, full_m};
  assign mism      = CHK_MASK & {exp_flags ^ mon_flags, |(exp_dout ^ mon_data_out)};

  always_ff @(posedge clk) begin
    if (mon_rst_n && wr_ok) mem[wp] <= mon_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      exp_dout   <= '0;
      exp_wr_ack <= 1'b0;
      exp_ovf    <= 1'b0;
      exp_udf    <= 1'b0;
    end else if (!mon_rst_n) begin
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      exp_dout   <= '0;
      exp_wr_ack <= 1'b0;
      exp_ovf    <= 1'b0;
      exp_udf    <= 1'b0;
    end else begin
      if (wr_ok) wp <= (wp == LAST_PTR) ? '0 : wp + PTR_W'(1);
      if (rd_ok) begin
        rp       <= (rp == LAST_PTR) ? '0 : rp + PTR_W'(1);
        exp_dout <= mem[rp];
      end
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + OCC_W'(1);
        2'b01:   cnt <= cnt - OCC_W'(1);
        default: cnt <= cnt;
      endcase
      exp_wr_ack <= wr_ok;
      exp_ovf    <= mon_wr_en && full_m;
      exp_udf    <= mon_rd_en && empty_m;
    end
  end

  // Model keeps tracking while chk_en is low; only the scoreboard freezes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid      <= 1'b0;
      cycle_cnt      <= '0;
      correct_cnt    <= '0;
      error_cnt      <= '0;
      err_sticky     <= 1'b0;
      first_err_mask <= '0;
      first_err_cyc  <= '0;
    end else begin
      cmp_valid <= 1'b1;
      if (cycle_cnt != SAT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (cmp_valid && chk_en) begin
        if (mism == '0) begin
          if (correct_cnt != SAT) correct_cnt <= correct_cnt + CNT_W'(1);
        end else begin
          if (error_cnt != SAT) error_cnt <= error_cnt + CNT_W'(1);
          if (!err_sticky) begin
            err_sticky     <= 1'b1;
            first_err_mask <= mism;
            first_err_cyc  <= cycle_cnt;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_sync_checker.sv
// Bench: queue-based golden FIFO drives the taps with deliberate corruption; a scoreboard model predicts checker outputs.
`timescale 1ns/1ps
module tb_fifo_sync_checker;
  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, chk_en, mon_rst_n, mon_wr_en, mon_rd_en;
  logic [W-1:0]  mon_data_in, mon_data_out;
  logic [6:0]    mon_flags;
  logic [15:0]   c_a, e_a, fc_a;
  logic          s_a, s_b;
  logic [7:0]    fm_a, fm_b;
  logic [3:0]    c_b, e_b, fc_b;

  fifo_sync_checker dut_a (
    .clk(clk), .rst(rst), .chk_en(chk_en), .mon_rst_n(mon_rst_n),
    .mon_wr_en(mon_wr_en), .mon_rd_en(mon_rd_en), .mon_data_in(mon_data_in),
    .mon_data_out(mon_data_out), .mon_flags(mon_flags),
    .correct_cnt(c_a), .error_cnt(e_a), .err_sticky(s_a),
    .first_err_mask(fm_a), .first_err_cyc(fc_a));

  fifo_sync_checker #(.CNT_W(4), .CHK_MASK(8'h7F)) dut_b (
    .clk(clk), .rst(rst), .chk_en(chk_en), .mon_rst_n(mon_rst_n),
    .mon_wr_en(mon_wr_en), .mon_rd_en(mon_rd_en), .mon_data_in(mon_data_in),
    .mon_data_out(mon_data_out), .mon_flags(mon_flags),
    .correct_cnt(c_b), .error_cnt(e_b), .err_sticky(s_b),
    .first_err_mask(fm_b), .first_err_cyc(fc_b));

  // Golden FIFO behaviour (what a correct FIFO would show on its outputs)
  logic [W-1:0] g_q[$];
  logic [W-1:0] g_dout = '0;
  bit           g_ack = 0, g_ovf = 0, g_udf = 0;
  bit           g_wok, g_rok;
  logic [7:0]   inj = '0;

  // Scoreboard model of the checker outputs, per instance
  int         m_corr[2], m_err[2], m_fcyc[2];
  bit         m_stk[2];
  logic [7:0] m_fmask[2];
  logic [7:0] mm;
  int         m_cyc = 0;
  bit         m_valid = 0;
  int         n_chk = 0, n_fail = 0;

  function automatic logic [7:0] msk(int i);
    return (i == 0) ? 8'hFF : 8'h7F;
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_corr[i] = 0; m_err[i] = 0; m_fcyc[i] = 0; m_stk[i] = 0; m_fmask[i] = '0;
      end
      m_cyc   = 0;
      m_valid = 0;
    end else begin
      if (m_valid && chk_en) begin
        for (int i = 0; i < 2; i++) begin
          mm = inj & msk(i);
          if (mm == '0) m_corr[i]++;
          else begin
            m_err[i]++;
            if (!m_stk[i]) begin
              m_stk[i] = 1; m_fmask[i] = mm; m_fcyc[i] = m_cyc;
            end
          end
        end
      end
      m_valid = 1;
      m_cyc++;
    end
    if (!mon_rst_n) begin
      g_q.delete();
      g_dout = '0; g_ack = 0; g_ovf = 0; g_udf = 0;
    end else begin
      g_wok = mon_wr_en && (g_q.size() < D);
      g_rok = mon_rd_en && (g_q.size() > 0);
      g_ovf = mon_wr_en && (g_q.size() == D);
      g_udf = mon_rd_en && (g_q.size() == 0);
      g_ack = g_wok;
      if (g_rok) g_dout = g_q.pop_front();
      if (g_wok) g_q.push_back(mon_data_in);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("a_correct_cnt", c_a, sat(m_corr[0], 16));
    chk("a_error_cnt", e_a, sat(m_err[0], 16));
    chk("a_err_sticky", s_a, m_stk[0]);
    chk("a_first_err_mask", fm_a, m_fmask[0]);
    chk("a_first_err_cyc", fc_a, sat(m_fcyc[0], 16));
    chk("b_correct_cnt", c_b, sat(m_corr[1], 4));
    chk("b_error_cnt", e_b, sat(m_err[1], 4));
    chk("b_err_sticky", s_b, m_stk[1]);
    chk("b_first_err_mask", fm_b, m_fmask[1]);
    chk("b_first_err_cyc", fc_b, sat(m_fcyc[1], 4));
  end

  // Present golden outputs (optionally corrupted) and hold inputs for one clock.
  task automatic step(input bit wr, input bit rd, input logic [W-1:0] din, input logic [7:0] fault);
    int sz;
    sz           = g_q.size();
    mon_wr_en    = wr;
    mon_rd_en    = rd;
    mon_data_in  = din;
    inj          = fault;
    mon_data_out = g_dout ^ {{(W-1){1'b0}}, fault[0]};
    mon_flags    = {g_ack, g_udf, g_ovf, sz == 1, sz == D-1, sz == 0, sz == D} ^ fault[7:1];
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mon_rst_n = 1'b0; chk_en = 1'b1;
    repeat (3) step(0, 0, '0, '0);
    chk("t1_rst_correct", c_a, 0);
    chk("t1_rst_mask", fm_a, 0);

    rst = 1'b0; mon_rst_n = 1'b1;
    repeat (5) step(0, 0, '0, '0);
    chk("t1_idle_correct", c_a, 4);
    chk("t1_idle_error", e_a, 0);

    for (int i = 1; i <= 9; i++) step(1, 0, W'(i), '0);
    chk("t2_model_ovf", g_ovf, 1);
    chk("t2_model_ack", g_ack, 0);
    chk("t2_model_cnt", g_q.size(), 8);
    step(0, 0, '0, '0);
    chk("t2_error", e_a, 0);

    for (int i = 1; i <= 8; i++) begin
      step(0, 1, '0, (i == 4) ? 8'h01 : 8'h00);
      chk("t3_model_dout", g_dout, i);
      if (i == 4) begin
        chk("t5_error_cnt", e_a, 1);
        chk("t5_sticky", s_a, 1);
        chk("t5_mask", fm_a, 8'h01);
        chk("t5_cyc", fc_a, 18);
        chk("t5_b_cyc", fc_b, 15);
      end
    end
    step(0, 1, '0, 8'h20);
    chk("t3_model_udf", g_udf, 1);
    step(0, 0, '0, '0);
    chk("t5_mask_held", fm_a, 8'h01);
    chk("t5_error_cnt2", e_a, 2);

    for (int i = 1; i <= 8; i++) step(1, 0, W'(16'h10 + i), '0);
    step(1, 1, 16'h55, '0);
    chk("t4_full_wr_rd_cnt", g_q.size(), 7);
    chk("t4_full_wr_rd_ack", g_ack, 0);
    chk("t4_full_wr_rd_dout", g_dout, 16'h11);
    repeat (7) step(0, 1, '0, '0);
    step(1, 1, 16'h77, '0);
    chk("t4_empty_wr_rd_cnt", g_q.size(), 1);
    chk("t4_empty_wr_rd_udf", g_udf, 1);
    chk("t4_empty_wr_rd_ack", g_ack, 1);
    step(0, 1, '0, '0);

    chk_en = 1'b0;
    repeat (5) step(1, 0, 16'hAAAA, 8'hFF);
    chk_en = 1'b1;
    step(0, 0, '0, '0);
    chk("chk_en_frozen_err", e_a, 2);

    rst = 1'b1; mon_rst_n = 1'b0;
    repeat (2) step(0, 0, '0, '0);
    rst = 1'b0; mon_rst_n = 1'b1;
    repeat (20) step(0, 0, '0, '0);
    chk("t6_a_correct", c_a, 19);
    chk("t6_b_saturated", c_b, 4'hF);
    step(1, 0, 16'h0100, '0);
    for (int i = 0; i < 10; i++) step(1, 1, W'($urandom), '0);
    mon_rst_n = 1'b0;
    step(0, 0, '0, '0);
    mon_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1, 1, W'($urandom), '0);
    chk("t6_no_false_err", e_a, 0);
    step(0, 0, '0, 8'h04);
    chk("t6_new_mask", fm_a, 8'h04);
    chk("t6_new_cyc", fc_a, 42);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] f;
      f = ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 19) == 0) chk_en = ~chk_en;
      mon_rst_n = ($urandom_range(0, 39) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), f);
    end
    chk_en = 1'b1; mon_rst_n = 1'b1;
    step(0, 0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
